// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam int   MULT_N_DEFAULT       = 8;
  localparam logic MULT_PRODUCT_RST_BIT = 1'b0;

  // Counter holds 0..N so it never wraps within an operation.
  function automatic int mult_cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/mult_ctrl.sv
// FSM and iteration counter for seq_multiplier; emits load/step/last/busy/done.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int N  = MULT_N_DEFAULT,
  parameter int CW = mult_cnt_w(N)
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic i_start,
  output logic o_load,
  output logic o_step,
  output logic o_last,
  output logic o_busy,
  output logic o_done
);
  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = CALC;
      CALC:    if (o_last)  w_state_nxt = DONE;
      DONE:    w_state_nxt = i_start ? CALC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // start is only honoured outside CALC, so a mid-operation pulse is dropped
  always_comb begin
    o_load = i_start && (r_state != CALC);
    o_step = (r_state == CALC);
    o_last = o_step && (r_cnt == CW'(N - 1));
    o_busy = (r_state == CALC);
    o_done = (r_state == DONE);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (o_load) r_cnt <= '0;
    else if (o_step) r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/seq_multiplier.sv
// N x N shift-add multiplier, one partial product per clock, start/done handshake.
// Define SEQ_MULT_SIGNED_EN to add the sgn port and two's-complement operand support.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int N = MULT_N_DEFAULT
) (
  input  logic           CLK,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic           sgn,
`endif
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  logic           w_load, w_step, w_last;
  logic [N-1:0]   r_mcand;
  logic [2*N:0]   r_acc;       // {acc_hi[N:0], acc_lo[N-1:0]}
  logic [N:0]     w_sum;
  logic [2*N-1:0] w_prod_raw;
  logic [2*N-1:0] w_prod_final;
  logic [N-1:0]   w_a_mag, w_b_mag;
  logic [2*N-1:0] r_product;

  mult_ctrl #(.N(N)) u_ctrl (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .i_start(start),
    .o_load (w_load),
    .o_step (w_step),
    .o_last (w_last),
    .o_busy (busy),
    .o_done (done)
  );

`ifdef SEQ_MULT_SIGNED_EN
  logic r_neg;
  // -2^(N-1) negates to itself, which reads correctly as the unsigned magnitude
  assign w_a_mag      = (sgn && a[N-1]) ? (~a + {{(N-1){1'b0}}, 1'b1}) : a;
  assign w_b_mag      = (sgn && b[N-1]) ? (~b + {{(N-1){1'b0}}, 1'b1}) : b;
  assign w_prod_final = r_neg ? (~w_prod_raw + {{(2*N-1){1'b0}}, 1'b1}) : w_prod_raw;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)      r_neg <= 1'b0;
    else if (w_load) r_neg <= sgn && (a[N-1] ^ b[N-1]);
  end
`else
  assign w_a_mag      = a;
  assign w_b_mag      = b;
  assign w_prod_final = w_prod_raw;
`endif

  assign w_sum      = r_acc[2*N:N] + (r_acc[0] ? {1'b0, r_mcand} : {(N+1){1'b0}});
  assign w_prod_raw = {w_sum, r_acc[N-1:1]};

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_product <= {(2*N){MULT_PRODUCT_RST_BIT}};
    end else if (w_load) begin
      r_mcand <= w_a_mag;
      r_acc   <= {{(N+1){1'b0}}, w_b_mag};
    end else if (w_step) begin
      r_acc <= {1'b0, w_prod_raw};
      if (w_last) r_product <= w_prod_final;
    end
  end

  assign product = r_product;
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (N = 8): driver queues expected products,
// a monitor checks value and done timing whenever done is seen.
module tb_seq_multiplier;
  localparam int N = 8;

  logic           CLK = 1'b0;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   a, b;
`ifdef SEQ_MULT_SIGNED_EN
  logic           sgn;
`endif
  logic           busy, done;
  logic [2*N-1:0] product;

  typedef struct {
    logic [2*N-1:0] prod;
    int             due;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  seq_multiplier #(.N(N)) dut (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
`ifdef SEQ_MULT_SIGNED_EN
    .sgn    (sgn),
`endif
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(product), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("product", 32'(product), 32'(e.prod));
        chk("done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Drive one accepted start; returns at the negedge after the start edge E0.
  task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic [2*N-1:0] exp);
    exp_t e;
    @(negedge CLK);
    a = ia; b = ib; start = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
    sgn = 1'b0;
`endif
    e.prod = exp; e.due = cyc + 1 + N;
    q.push_back(e);
    @(negedge CLK);
    start = 1'b0;
  endtask

`ifdef SEQ_MULT_SIGNED_EN
  task automatic issue_s(input logic s, input logic [N-1:0] ia, input logic [N-1:0] ib,
                         input logic [2*N-1:0] exp);
    exp_t e;
    @(negedge CLK);
    a = ia; b = ib; sgn = s; start = 1'b1;
    e.prod = exp; e.due = cyc + 1 + N;
    q.push_back(e);
    @(negedge CLK);
    start = 1'b0;
  endtask
`endif

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) begin
      @(negedge CLK); #1;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
`ifdef SEQ_MULT_SIGNED_EN
    sgn = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    rst_n = 1'b1;

    // 255 x 255: busy E1..E8, done only at E8
    issue(8'd255, 8'd255, 16'hFE01);
    chk("t1_busy_e0", 32'(busy), 32'd1);
    repeat (7) @(negedge CLK);
    chk("t1_busy_e7", 32'(busy), 32'd1);
    chk("t1_done_e7", 32'(done), 32'd0);
    @(negedge CLK);
    chk("t1_busy_e8", 32'(busy), 32'd0);
    @(negedge CLK);
    chk("t1_done_e9", 32'(done), 32'd0);
    chk("t1_busy_e9", 32'(busy), 32'd0);
    drain();

    // zero and unit multiplicands; product holds in IDLE
    issue(8'd0, 8'd173, 16'd0);
    drain();
    repeat (3) @(negedge CLK);
    chk("t2_hold0", 32'(product), 32'd0);
    issue(8'd1, 8'd173, 16'd173);
    drain();
    repeat (3) @(negedge CLK);
    chk("t2_hold173", 32'(product), 32'd173);

    // start during CALC is ignored
    issue(8'd12, 8'd10, 16'd120);
    repeat (2) @(negedge CLK);
    a = 8'd3; b = 8'd3; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("t3_busy_after_restart", 32'(busy), 32'd1);
    drain();

    // back-to-back with start held high
    @(negedge CLK);
    a = 8'd5; b = 8'd7; start = 1'b1;
    e.prod = 16'd35; e.due = cyc + 1 + N; q.push_back(e);
    repeat (9) @(negedge CLK);
    a = 8'd9; b = 8'd9;
    e.prod = 16'd81; e.due = cyc + 1 + N; q.push_back(e);
    @(negedge CLK);
    start = 1'b0;
    chk("t4_busy_e9", 32'(busy), 32'd1);
    chk("t4_done_e9", 32'(done), 32'd0);
    drain();

    // async reset mid-operation discards the result
    @(negedge CLK);
    a = 8'd13; b = 8'd11; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    chk("t5_rst_product", 32'(product), 32'd0);
    @(negedge CLK);
    rst_n = 1'b1;
    issue(8'd2, 8'd3, 16'd6);
    drain();

    // extra unsigned corners
    issue(8'h80, 8'h80, 16'h4000);
    drain();
    issue(8'd200, 8'd3, 16'd600);
    drain();

`ifdef SEQ_MULT_SIGNED_EN
    issue_s(1'b1, 8'h80, 8'h80, 16'h4000);
    drain();
    issue_s(1'b1, 8'hFD, 8'd5, 16'hFFF1);
    drain();
    issue_s(1'b1, 8'd127, 8'hFF, 16'hFF81);
    drain();
    issue_s(1'b0, 8'h80, 8'h80, 16'h4000);
    drain();
`endif

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
